// File: rtl/cache_mem_arbiter.sv
// Arbitrates one RAM port between the fetch and data channels. Data has priority;
// a starvation counter forces fetch through, and a timeout aborts stuck accesses.
module cache_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
  typedef enum logic [1:0] {RS_FREE, RS_BUSY, RS_ACCESS, RS_ERROR} ramstate_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            err_q, err_d;

  ramstate_t rs;
  logic      d_req, grant, own_req, complete, timeout;

  assign rs       = ramstate_t'(ramstate);
  assign d_req    = dREN | dWEN;
  assign grant    = (state_q == IACC) || (state_q == DACC);
  assign own_req  = (state_q == IACC) ? iREN : (state_q == DACC) ? d_req : 1'b0;
  // ERROR ends the access just like ACCESS; a dropped request ends it silently.
  assign complete = grant && own_req && ((rs == RS_ACCESS) || (rs == RS_ERROR));
  assign timeout  = grant && own_req && !complete && (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (!iREN) starve_cnt_d = '0;
        if (iREN && (starve_cnt_q >= SW'(STARVE_LIMIT))) state_d = IACC;
        else if (d_req)                                  state_d = DACC;
        else if (iREN)                                   state_d = IACC;
      end
      IACC, DACC: begin
        if (rs == RS_ERROR || timeout) err_d = 1'b1;
        if (complete) begin
          if (state_q == IACC)
            starve_cnt_d = '0;
          else if (iREN && (starve_cnt_q < SW'(STARVE_LIMIT)))
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
        if (!own_req || complete || timeout) begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = d_req;
    iload    = '0;
    dload    = '0;
    case (state_q)
      IACC: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (complete || timeout) iwait = 1'b0;
        if (complete)            iload = ramload;
      end
      DACC: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (complete || timeout) dwait = 1'b0;
        if (complete)            dload = ramload;
      end
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus random traffic, all checked
// every cycle against an owner/counter model of the arbitration rules.
module tb_cache_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = '0;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  bit          s_rst, s_iren, s_dren, s_dwen;
  logic [31:0] s_iaddr, s_daddr, s_dstore, s_rload;
  logic [1:0]  s_rs;

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data) and for how long
  int m_owner, m_cycles, m_starve;
  bit m_err;

  task automatic set_idle();
    s_rst = 0; s_iren = 0; s_dren = 0; s_dwen = 0;
    s_iaddr = '0; s_daddr = '0; s_dstore = '0; s_rload = '0; s_rs = 2'd0;
  endtask

  task automatic step();
    bit dreq, oreq, fin, expd;
    int nxt;
    logic [31:0] e_rren, e_rwen, e_raddr, e_rstore, e_iw, e_il, e_dw, e_dl;
    @(posedge CLK);
    #1;
    RST = s_rst; iREN = s_iren; dREN = s_dren; dWEN = s_dwen;
    iaddr = s_iaddr; daddr = s_daddr; dstore = s_dstore;
    ramload = s_rload; ramstate = s_rs;
    if (s_rst) begin
      m_owner = 0; m_cycles = 0; m_starve = 0; m_err = 0;
    end
    #1;
    dreq = s_dren || s_dwen;
    oreq = (m_owner == 1) ? s_iren : (m_owner == 2) ? dreq : 1'b0;
    fin  = (m_owner != 0) && oreq && (s_rs == 2'd2 || s_rs == 2'd3);
    expd = (m_owner != 0) && oreq && !fin && (m_cycles == TIMEOUT - 1);

    e_rren   = (m_owner == 1) ? 32'(s_iren) : (m_owner == 2) ? 32'(s_dren && !s_dwen) : 32'd0;
    e_rwen   = 32'((m_owner == 2) && s_dwen);
    e_raddr  = (m_owner == 1) ? s_iaddr : (m_owner == 2) ? s_daddr : 32'd0;
    e_rstore = (m_owner == 2) ? s_dstore : 32'd0;
    e_iw     = 32'(s_iren && !((m_owner == 1) && (fin || expd)));
    e_dw     = 32'(dreq && !((m_owner == 2) && (fin || expd)));
    e_il     = ((m_owner == 1) && fin) ? s_rload : 32'd0;
    e_dl     = ((m_owner == 2) && fin) ? s_rload : 32'd0;

    chk("ramREN",   32'(ramREN), e_rren);
    chk("ramWEN",   32'(ramWEN), e_rwen);
    chk("ramaddr",  ramaddr,     e_raddr);
    chk("ramstore", ramstore,    e_rstore);
    chk("iwait",    32'(iwait),  e_iw);
    chk("iload",    iload,       e_il);
    chk("dwait",    32'(dwait),  e_dw);
    chk("dload",    dload,       e_dl);
    chk("err",      32'(err),    32'(m_err));

    if (!s_rst) begin
      if (m_owner == 0) begin
        nxt = (s_iren && m_starve >= STARVE_LIMIT) ? 1 : dreq ? 2 : s_iren ? 1 : 0;
        if (!s_iren) m_starve = 0;
        m_owner  = nxt;
        m_cycles = 0;
      end else begin
        if (s_rs == 2'd3 || expd) m_err = 1;
        if (fin && m_owner == 1) m_starve = 0;
        if (fin && m_owner == 2 && s_iren && m_starve < STARVE_LIMIT) m_starve++;
        if (!oreq || fin || expd) begin
          m_owner = 0; m_cycles = 0;
        end else begin
          m_cycles++;
        end
      end
    end
  endtask

  initial begin
    m_owner = 0; m_cycles = 0; m_starve = 0; m_err = 0;

    // Reset state
    set_idle(); s_rst = 1; step();
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_err",    32'(err),    32'd0);
    set_idle(); step();

    // Fetch only: ACCESS two cycles after grant
    s_iren = 1; s_iaddr = 32'h40; step();
    s_rs = 2'd1; step();
    chk("fetch_grant_ramREN", 32'(ramREN), 32'd1);
    chk("fetch_grant_addr",   ramaddr,     32'h40);
    step();
    chk("fetch_busy_iwait", 32'(iwait), 32'd1);
    s_rs = 2'd2; s_rload = 32'hDEADBEEF; step();
    chk("fetch_done_iwait", 32'(iwait), 32'd0);
    chk("fetch_done_iload", iload,      32'hDEADBEEF);
    set_idle(); step();

    // Simultaneous fetch and data write: data wins, then IDLE, then fetch
    s_iren = 1; s_iaddr = 32'h44; s_dwen = 1; s_daddr = 32'h80; s_dstore = 32'h1234; step();
    s_rs = 2'd2; step();
    chk("sim_ramWEN",   32'(ramWEN), 32'd1);
    chk("sim_ramstore", ramstore,    32'h1234);
    chk("sim_ramaddr",  ramaddr,     32'h80);
    chk("sim_iwait",    32'(iwait),  32'd1);
    s_dwen = 0; s_rs = 2'd0; step();
    chk("sim_gap_ramREN", 32'(ramREN), 32'd0);
    s_rs = 2'd1; step();
    chk("sim_fetch_ramREN", 32'(ramREN), 32'd1);
    chk("sim_fetch_addr",   ramaddr,     32'h44);
    s_rs = 2'd2; s_rload = 32'h11; step();
    set_idle(); step();

    // Starvation: fetch held, data re-requested every IDLE
    s_iren = 1; s_iaddr = 32'h100; s_dren = 1; s_daddr = 32'h200;
    for (int k = 0; k < 10; k++) begin
      s_rs = 2'd0; step();
      s_rs = 2'd2; s_rload = 32'(k); step();
      chk("starve_fetch_grant", 32'(!iwait), 32'(k == 4 || k == 9));
    end
    set_idle(); step();

    // RAM ERROR during fetch
    s_iren = 1; s_iaddr = 32'h300; step();
    s_rs = 2'd3; s_rload = 32'h5555; step();
    chk("error_iwait", 32'(iwait), 32'd0);
    chk("error_iload", iload,      32'h5555);
    s_rs = 2'd0; s_rload = '0; s_iren = 0; step();
    chk("error_err",    32'(err),    32'd1);
    chk("error_ramREN", 32'(ramREN), 32'd0);

    // Reset mid-access: write granted, RST pulse, then regrant
    s_dren = 1; s_dwen = 1; s_daddr = 32'h400; s_dstore = 32'h77; step();
    s_rs = 2'd1; step();
    chk("rstmid_ramWEN_before", 32'(ramWEN), 32'd1);
    s_rst = 1; step();
    chk("rstmid_ramWEN", 32'(ramWEN), 32'd0);
    chk("rstmid_ramREN", 32'(ramREN), 32'd0);
    chk("rstmid_err",    32'(err),    32'd0);
    s_rst = 0; step();
    chk("rstmid_idle", 32'(ramWEN), 32'd0);
    step();
    chk("rstmid_regrant", 32'(ramWEN), 32'd1);
    s_rs = 2'd2; step();
    set_idle(); step();

    // Timeout on a data read held BUSY
    s_dren = 1; s_daddr = 32'h500; s_rload = 32'hCAFE; step();
    s_rs = 2'd1;
    for (int c = 0; c < TIMEOUT; c++) begin
      step();
      if (c == TIMEOUT - 2) chk("tmo_still_waiting", 32'(dwait), 32'd1);
    end
    chk("tmo_dwait", 32'(dwait), 32'd0);
    chk("tmo_dload", dload,      32'd0);
    set_idle(); step();
    chk("tmo_err", 32'(err), 32'd1);
    s_iren = 1; s_iaddr = 32'h600; step();
    s_rs = 2'd2; s_rload = 32'h9; step();
    set_idle(); step();
    chk("tmo_err_sticky", 32'(err), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      if ($urandom_range(0, 9) < 3) begin
        s_iren  = 1'($urandom_range(0, 1));
        s_iaddr = $urandom();
      end
      if ($urandom_range(0, 9) < 3) begin
        s_dren   = 1'($urandom_range(0, 1));
        s_dwen   = 1'($urandom_range(0, 1));
        s_daddr  = $urandom();
        s_dstore = $urandom();
      end
      r = int'($urandom_range(0, 49));
      s_rs    = (r < 20) ? 2'd1 : (r < 30) ? 2'd0 : (r < 48) ? 2'd2 : 2'd3;
      s_rload = $urandom();
      s_rst   = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
